// File: rtl/ii_pkg.sv
// Shared constants, eot field type and output-width helper for the integral-image stage.
package ii_pkg;

   localparam int unsigned EOT_ROW = 0;
   localparam int unsigned EOT_WIN = 1;

   typedef logic [1:0] eot_t;

   // Minimum accumulator width that holds a full window of maximum-valued pixels.
   function automatic int unsigned ii_width(input int unsigned w_data,
                                            input int unsigned fw,
                                            input int unsigned fh);
      return w_data + $clog2(fw * fh);
   endfunction

endpackage

// File: rtl/integral_image_gen_if.sv
// Pixel-in / integral-out stream bundle; master drives pixels and downstream ready.
interface integral_image_gen_if
   import ii_pkg::*;
#(
   parameter int unsigned W_DATA = 8,
   parameter int unsigned W_II   = 18
) ();

   logic              din_valid;
   logic              din_ready;
   logic [W_DATA-1:0] din_data;
   eot_t              din_eot;
   logic              dout_valid;
   logic              dout_ready;
   logic [W_II-1:0]   dout_data;
   eot_t              dout_eot;

   modport master (
      output din_valid, din_data, din_eot, dout_ready,
      input  din_ready, dout_valid, dout_data, dout_eot
   );

   modport slave (
      input  din_valid, din_data, din_eot, dout_ready,
      output din_ready, dout_valid, dout_data, dout_eot
   );

endinterface

// File: rtl/ii_line_buf.sv
// Previous-row integral values: one synchronous write port, one combinational read port, no reset.
module ii_line_buf #(
   parameter int unsigned DEPTH = 24,
   parameter int unsigned WIDTH = 18,
   parameter int unsigned AW    = 5
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/integral_image_gen.sv
// Streaming integral image: row running sum plus previous row's integral from the line buffer.
module integral_image_gen
   import ii_pkg::*;
#(
   parameter int unsigned FEATURE_WIDTH  = 24,
   parameter int unsigned FEATURE_HEIGHT = 24,
   parameter int unsigned W_DATA         = 8,
   parameter int unsigned W_II           = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   integral_image_gen_if.slave  bus,
   output logic                 err
);

   localparam int unsigned XW = (FEATURE_WIDTH > 1) ? $clog2(FEATURE_WIDTH) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(FEATURE_WIDTH - 1);

   if (W_II < ii_width(W_DATA, FEATURE_WIDTH, FEATURE_HEIGHT)) begin : g_w_ii_chk
      $error("integral_image_gen: W_II too narrow for window size");
   end

   logic [XW-1:0]   x_q, x_d;
   logic [W_II-1:0] row_sum_q, row_sum_d;
   logic            first_row_q, first_row_d;
   logic            dout_valid_q, dout_valid_d;
   logic [W_II-1:0] dout_data_q, dout_data_d;
   eot_t            dout_eot_q, dout_eot_d;
   logic            err_q, err_d;

   logic            din_ready;
   logic            in_hs;
   logic            out_hs;
   logic [W_II-1:0] rs;
   logic [W_II-1:0] ii_sum;
   logic [W_II-1:0] line_rd;

   assign din_ready = !dout_valid_q || bus.dout_ready;
   assign in_hs     = bus.din_valid && din_ready;
   assign out_hs    = dout_valid_q && bus.dout_ready;

   ii_line_buf #(
      .DEPTH (FEATURE_WIDTH),
      .WIDTH (W_II),
      .AW    (XW)
   ) u_line_buf (
      .clk   (clk),
      .we    (in_hs),
      .waddr (x_q),
      .wdata (ii_sum),
      .raddr (x_q),
      .rdata (line_rd)
   );

   always_comb begin
      x_d          = x_q;
      row_sum_d    = row_sum_q;
      first_row_d  = first_row_q;
      dout_valid_d = dout_valid_q;
      dout_data_d  = dout_data_q;
      dout_eot_d   = dout_eot_q;
      err_d        = err_q;

      rs     = ((x_q == '0) ? '0 : row_sum_q) + W_II'(bus.din_data);
      ii_sum = rs + (first_row_q ? '0 : line_rd);

      if (in_hs) begin
         row_sum_d    = rs;
         dout_data_d  = ii_sum;
         dout_eot_d   = bus.din_eot;
         dout_valid_d = 1'b1;

         // Window end wins over row end; a missing row marker at the last column wraps x.
         if (bus.din_eot[EOT_WIN]) begin
            x_d         = '0;
            first_row_d = 1'b1;
         end else if (bus.din_eot[EOT_ROW]) begin
            x_d         = '0;
            first_row_d = 1'b0;
         end else if (x_q == X_LAST) begin
            x_d = '0;
         end else begin
            x_d = x_q + 1'b1;
         end

         if ((x_q == X_LAST && !bus.din_eot[EOT_ROW]) ||
             (bus.din_eot[EOT_WIN] && !bus.din_eot[EOT_ROW])) begin
            err_d = 1'b1;
         end
      end else if (out_hs) begin
         dout_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q          <= '0;
         row_sum_q    <= '0;
         first_row_q  <= 1'b1;
         dout_valid_q <= 1'b0;
         dout_data_q  <= '0;
         dout_eot_q   <= '0;
         err_q        <= 1'b0;
      end else begin
         x_q          <= x_d;
         row_sum_q    <= row_sum_d;
         first_row_q  <= first_row_d;
         dout_valid_q <= dout_valid_d;
         dout_data_q  <= dout_data_d;
         dout_eot_q   <= dout_eot_d;
         err_q        <= err_d;
      end
   end

   assign bus.din_ready  = din_ready;
   assign bus.dout_valid = dout_valid_q;
   assign bus.dout_data  = dout_data_q;
   assign bus.dout_eot   = dout_eot_q;
   assign err            = err_q;

endmodule

// File: tb/tb_integral_image_gen.sv
// Randomized bench for integral_image_gen against a window-sum reference model.
module tb_integral_image_gen;
   import ii_pkg::*;

   localparam int unsigned FW = 24;
   localparam int unsigned FH = 24;
   localparam int unsigned WD = 8;
   localparam int unsigned WI = 18;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err;

   integral_image_gen_if #(.W_DATA(WD), .W_II(WI)) bus ();

   integral_image_gen #(
      .FEATURE_WIDTH  (FW),
      .FEATURE_HEIGHT (FH),
      .W_DATA         (WD),
      .W_II           (WI)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus),
      .err (err)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model state: pixels of the current window and its cursor.
   int unsigned  pix [FH][FW];
   int unsigned  mx = 0;
   int unsigned  my = 0;
   logic [19:0]  exp_q [$];
   logic [19:0]  obs_q [$];
   int unsigned  win_first_q [$];
   bit           next_first = 1'b1;
   bit           mdl_en = 1'b1;
   bit           gap_en = 1'b0;
   int unsigned  ready_pct = 100;
   int unsigned  last_data = 0;
   int unsigned  max_seen = 0;
   bit           prev_stall = 1'b0;
   logic [WI-1:0] prev_data;
   logic [1:0]   prev_eot;

   initial begin
      bus.dout_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.dout_ready = ($urandom_range(99) < ready_pct);
      end
   end

   always @(negedge clk) begin
      logic [19:0] e;
      int unsigned s;
      if (rst) begin
         exp_q.delete();
         mx = 0;
         my = 0;
         prev_stall = 1'b0;
         next_first = 1'b1;
      end else begin
         if (prev_stall && mdl_en) begin
            chk_eq("stall_valid", 32'(bus.dout_valid), 32'd1);
            chk_eq("stall_data", 32'(bus.dout_data), 32'(prev_data));
            chk_eq("stall_eot", 32'(bus.dout_eot), 32'(prev_eot));
         end
         if (bus.dout_valid && bus.dout_ready && mdl_en) begin
            if (exp_q.size() == 0) begin
               chk_eq("spurious_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk_eq("out_data", 32'(bus.dout_data), 32'(e[17:0]));
               chk_eq("out_eot", 32'(bus.dout_eot), 32'(e[19:18]));
            end
            obs_q.push_back({bus.dout_eot, bus.dout_data});
            last_data = 32'(bus.dout_data);
            if (last_data > max_seen) max_seen = last_data;
            if (next_first) win_first_q.push_back(last_data);
            next_first = bus.dout_eot[EOT_WIN];
         end
         if (bus.din_valid && bus.din_ready && mdl_en) begin
            if (my < FH && mx < FW) pix[my][mx] = 32'(bus.din_data);
            s = 0;
            for (int unsigned j = 0; j <= my && j < FH; j++)
               for (int unsigned i = 0; i <= mx && i < FW; i++)
                  s += pix[j][i];
            exp_q.push_back({bus.din_eot, s[17:0]});
            if (bus.din_eot[EOT_WIN]) begin
               mx = 0;
               my = 0;
            end else if (bus.din_eot[EOT_ROW]) begin
               mx = 0;
               my++;
            end else begin
               mx++;
            end
         end
         prev_stall = bus.dout_valid && !bus.dout_ready;
         prev_data  = bus.dout_data;
         prev_eot   = bus.dout_eot;
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.din_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic send_pixel(input logic [WD-1:0] d, input logic [1:0] eot);
      bit hs;
      hs = 1'b0;
      if (gap_en && $urandom_range(3) == 0) begin
         bus.din_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      bus.din_valid = 1'b1;
      bus.din_data  = d;
      bus.din_eot   = eot;
      for (int c = 0; c < 1000 && !hs; c++) begin
         @(negedge clk);
         hs = bus.din_ready;
         @(posedge clk);
         #1;
      end
      if (!hs) chk_eq("din_hs_timeout", 32'd0, 32'd1);
      bus.din_valid = 1'b0;
   endtask

   // mode 0: constant cval, 1: ramp p=x, 2: random
   task automatic send_window(input int mode, input logic [WD-1:0] cval);
      logic [WD-1:0] d;
      logic [1:0]    eot;
      for (int unsigned y = 0; y < FH; y++) begin
         for (int unsigned x = 0; x < FW; x++) begin
            case (mode)
               0:       d = cval;
               1:       d = WD'(x);
               default: d = WD'($urandom_range(255));
            endcase
            eot = {(x == FW - 1) && (y == FH - 1), x == FW - 1};
            send_pixel(d, eot);
         end
      end
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 2000) begin
         @(posedge clk);
         #1;
         c++;
      end
      chk_eq("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.din_valid = 1'b0;
      bus.din_data  = '0;
      bus.din_eot   = '0;
      ready_pct     = 0;
      do_reset();
      chk_eq("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
      chk_eq("rst_dout_data", 32'(bus.dout_data), 32'd0);
      chk_eq("rst_dout_eot", 32'(bus.dout_eot), 32'd0);
      chk_eq("rst_err", 32'(err), 32'd0);
      chk_eq("rst_din_ready", 32'(bus.din_ready), 32'd1);

      // All ones, no backpressure.
      ready_pct = 100;
      obs_q.delete();
      send_window(0, 8'd1);
      drain();
      chk_eq("ones_count", 32'(obs_q.size()), 32'(FW * FH));
      chk_eq("ones_first", 32'(obs_q[0]), {12'd0, 2'b00, 18'd1});
      chk_eq("ones_row0_end", 32'(obs_q[FW - 1]), {12'd0, 2'b01, 18'd24});
      chk_eq("ones_final", 32'(obs_q[FW * FH - 1]), {12'd0, 2'b11, 18'd576});
      chk_eq("ones_err", 32'(err), 32'd0);

      // All 255: maximum value reached only at the last pixel.
      max_seen = 0;
      send_window(0, 8'd255);
      drain();
      chk_eq("max_final", last_data, 32'd146880);
      chk_eq("max_peak", max_seen, 32'd146880);

      // Ramp then all 2s, back to back: no carry across windows.
      win_first_q.delete();
      send_window(1, 8'd0);
      send_window(0, 8'd2);
      drain();
      chk_eq("b2b_count", 32'(win_first_q.size()), 32'd2);
      chk_eq("ramp_first", win_first_q[0], 32'd0);
      chk_eq("twos_first", win_first_q[1], 32'd2);
      chk_eq("twos_final", last_data, 32'd1152);

      // Random pixels, random backpressure and input gaps.
      ready_pct = 50;
      gap_en    = 1'b1;
      for (int w = 0; w < 3; w++) send_window(2, 8'd0);
      drain();
      chk_eq("rand_err", 32'(err), 32'd0);
      ready_pct = 100;
      gap_en    = 1'b0;

      // Framing error: 24th pixel of a row without row marker.
      do_reset();
      mdl_en = 1'b0;
      for (int x = 0; x < 23; x++) send_pixel(8'd1, 2'b00);
      chk_eq("err_before", 32'(err), 32'd0);
      send_pixel(8'd1, 2'b00);
      chk_eq("err_rise", 32'(err), 32'd1);
      for (int x = 0; x < 5; x++) send_pixel(8'd1, 2'b00);
      repeat (10) @(posedge clk);
      #1;
      chk_eq("err_sticky", 32'(err), 32'd1);
      do_reset();
      chk_eq("err_cleared", 32'(err), 32'd0);
      mdl_en = 1'b1;

      // Reset in mid-window at (10,5), then a fresh all-ones window.
      for (int k = 0; k < 5 * FW + 10; k++)
         send_pixel(8'd1, {1'b0, (k % FW) == FW - 1});
      do_reset();
      obs_q.delete();
      send_window(0, 8'd1);
      drain();
      chk_eq("post_rst_count", 32'(obs_q.size()), 32'(FW * FH));
      chk_eq("post_rst_first", 32'(obs_q[0]), {12'd0, 2'b00, 18'd1});
      chk_eq("post_rst_final", 32'(obs_q[FW * FH - 1]), {12'd0, 2'b11, 18'd576});
      chk_eq("post_rst_err", 32'(err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/integral_image_gen.md
# integral_image_gen

Streaming integral-image stage that consumes the pixel stream marked by the end-of-transfer generator. `dout_eot[0]` marks end of row and `dout_eot[1]` marks end of window. For each FEATURE_WIDTH x FEATURE_HEIGHT window, the block emits the integral value ii(x,y) = sum of p(i,j) over i<=x, j<=y, one output per input pixel, with the eot markers carried alongside. It feeds the feature-evaluation stages, which need rectangle sums from four integral lookups.

## Interface
- FEATURE_WIDTH, 24, pixels per window row.
- FEATURE_HEIGHT, 24, rows per window.
- W_DATA, 8, input pixel width.
- W_II, 18, output width. Must be >= W_DATA + $clog2(FEATURE_WIDTH*FEATURE_HEIGHT); an elaboration assertion enforces this.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- din_valid  in  1  input pixel valid.
- din_ready  out  1  input ready.
- din_data  in  W_DATA  pixel, unsigned.
- din_eot  in  2  [0] last pixel of row, [1] last pixel of window.
- dout_valid  out  1  output valid.
- dout_ready  in  1  downstream ready.
- dout_data  out  W_II  integral value, unsigned.
- dout_eot  out  2  registered copy of din_eot for the same pixel.
- err  out  1  sticky framing error flag.

## Operation
- Input handshake: din_valid & din_ready. Output handshake: dout_valid & dout_ready.
- State:
  - x_reg, column index, $clog2(FEATURE_WIDTH) bits.
  - row_sum, W_II bits, running sum of the current row.
  - first_row, 1 bit.
  - Line buffer of FEATURE_WIDTH x W_II entries, holding the previous row's integral values.
- On each accepted pixel p:
  - rs = (x_reg==0 ? 0 : row_sum) + p.
  - ii = rs + (first_row ? 0 : line[x_reg]).
  - Write line[x_reg] <= ii and row_sum <= rs.
  - Load the output register: dout_data <= ii, dout_eot <= din_eot.
- Position update on an accepted pixel:
  - din_eot[0]=1: x_reg <= 0 and first_row <= 0.
  - din_eot[1]=1 (with or without [0]): x_reg <= 0 and first_row <= 1.
  - Otherwise: x_reg <= x_reg + 1.
- Framing errors set err and hold it until rst:
  - Pixel accepted at x_reg==FEATURE_WIDTH-1 without din_eot[0]. The pixel is processed normally and x_reg wraps to 0.
  - din_eot[1] without din_eot[0]. The block treats this as a window end: x_reg=0, first_row=1.
  - The block never counts rows. Window end is taken solely from din_eot[1].
- Arithmetic is unsigned, modulo 2^W_II. Overflow cannot occur under the W_II rule.
- The line buffer is not reset. first_row masks its stale contents.

## Timing
- Latency is 1 cycle from input handshake to dout_valid. Throughput is 1 pixel/cycle.
- Flow control: din_ready = !dout_valid | dout_ready. This is a combinational path from dout_ready.
- The output register loads on an input handshake and clears dout_valid on an output handshake with no new input.
- While dout_valid=1 and dout_ready=0, dout_data and dout_eot hold stable.
- Simultaneous output handshake and input handshake in one cycle: the new value is loaded and dout_valid stays 1.
- Line buffer: written at the clock edge of the input handshake and read combinationally at x_reg. The entry for column x from row y-1 is always written before row y reads it.
- Values after rst:
  - dout_valid=0, dout_data=0, dout_eot=0, err=0.
  - x_reg=0, row_sum=0, first_row=1.
  - din_ready=1 in the cycle after rst deasserts.
- rst during a window discards the partial window. The next accepted pixel is treated as (0,0).

## Structure
- Shared package ii_pkg holds:
  - Constants EOT_ROW=0 and EOT_WIN=1.
  - Function ii_width(w_data, fw, fh) returning the minimum W_II.
  - typedef for the eot field (logic [1:0]).
- Sub-module ii_line_buf: FEATURE_WIDTH x W_II register array with one write port and one combinational read port. It has no reset.
- The top level holds the counters, adders, output register and error logic.

## Test plan
- 24x24 window of all 1s, no backpressure:
  - Output at (x,y) = (x+1)*(y+1).
  - First output 1, row 0 end 24 with eot=01.
  - Final output 576 with eot=11.
  - err=0.
- 24x24 window of all 255: final output 146880, and no intermediate value exceeds it.
- Two back-to-back windows, ramp p=x then all 2s: the first output of window 2 equals 2, so no carry from window 1.
- Random dout_ready at 50% duty over 3 windows: the output sequence matches the golden model exactly, and dout_data/dout_eot are stable while stalled.
- Row with 24 pixels and no eot[0] on the 24th pixel: err rises the cycle after that handshake and stays 1 until rst.
- rst asserted at pixel (10,5), then a fresh all-1s window: outputs match the first scenario and err=0.
